// File: rtl/alu_vector_checker_if.sv
// Bus bundle between the ALU self-test sequencer and its ROM/ALU/control surroundings.
// master is the sequencer side; slave is the wrapper that hosts the ROM and ALU.
interface alu_vector_checker_if #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [ADDR_W:0]   num_vectors;
  logic [ADDR_W-1:0] vec_addr;
  logic [103:0]      vec_data;
  logic [31:0]       a;
  logic [31:0]       b;
  logic [1:0]        ALUControl;
  logic [31:0]       Result;
  logic [3:0]        ALUFlags;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  pass_count;
  logic [CNT_W-1:0]  fail_count;
  logic              fail_seen;
  logic [ADDR_W-1:0] first_fail_idx;

  modport master (
    input  start, num_vectors, vec_data, Result, ALUFlags,
    output vec_addr, a, b, ALUControl, busy, done,
           pass_count, fail_count, fail_seen, first_fail_idx
  );

  modport slave (
    output start, num_vectors, vec_data, Result, ALUFlags,
    input  vec_addr, a, b, ALUControl, busy, done,
           pass_count, fail_count, fail_seen, first_fail_idx
  );
endinterface

// File: rtl/alu_vector_checker.sv
// ALU built-in self-test sequencer: fetches vectors from a synchronous ROM, drives the ALU,
// checks Result/ALUFlags against the expected fields and accumulates pass/fail statistics.
module alu_vector_checker #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic clk,
  input  logic reset,
  alu_vector_checker_if.master bus
);
  typedef enum logic [2:0] {IDLE, READ, LOAD, CHECK, DONE} state_t;

  localparam logic [ADDR_W:0]   MAX_VEC = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   NUM_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   num_reg, num_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic [31:0]       a_reg, a_next;
  logic [31:0]       b_reg, b_next;
  logic [1:0]        ctrl_reg, ctrl_next;
  logic [31:0]       exp_res_reg, exp_res_next;
  logic [3:0]        exp_flags_reg, exp_flags_next;
  logic [CNT_W-1:0]  pass_reg, pass_next;
  logic [CNT_W-1:0]  fail_reg, fail_next;
  logic              seen_reg, seen_next;
  logic [ADDR_W-1:0] first_reg, first_next;

  logic [ADDR_W:0]   num_clamped;
  logic              vec_match;
  logic              unused_bits;

  assign num_clamped = (bus.num_vectors > MAX_VEC) ? MAX_VEC : bus.num_vectors;
  assign vec_match   = (bus.Result == exp_res_reg) && (bus.ALUFlags == exp_flags_reg);
  assign unused_bits = ^bus.vec_data[103:102];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      num_reg       <= '0;
      idx_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      ctrl_reg      <= '0;
      exp_res_reg   <= '0;
      exp_flags_reg <= '0;
      pass_reg      <= '0;
      fail_reg      <= '0;
      seen_reg      <= 1'b0;
      first_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      num_reg       <= num_next;
      idx_reg       <= idx_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      ctrl_reg      <= ctrl_next;
      exp_res_reg   <= exp_res_next;
      exp_flags_reg <= exp_flags_next;
      pass_reg      <= pass_next;
      fail_reg      <= fail_next;
      seen_reg      <= seen_next;
      first_reg     <= first_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    num_next       = num_reg;
    idx_next       = idx_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    ctrl_next      = ctrl_reg;
    exp_res_next   = exp_res_reg;
    exp_flags_next = exp_flags_reg;
    pass_next      = pass_reg;
    fail_next      = fail_reg;
    seen_next      = seen_reg;
    first_next     = first_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          pass_next  = '0;
          fail_next  = '0;
          seen_next  = 1'b0;
          first_next = '0;
          num_next   = num_clamped;
          idx_next   = '0;
          state_next = (num_clamped == '0) ? DONE : READ;
        end
      end
      READ: state_next = LOAD;
      LOAD: begin
        ctrl_next      = bus.vec_data[101:100];
        a_next         = bus.vec_data[99:68];
        b_next         = bus.vec_data[67:36];
        exp_res_next   = bus.vec_data[35:4];
        exp_flags_next = bus.vec_data[3:0];
        state_next     = CHECK;
      end
      CHECK: begin
        if (vec_match) begin
          if (pass_reg != CNT_MAX) pass_next = pass_reg + CNT_ONE;
        end else begin
          if (fail_reg != CNT_MAX) fail_next = fail_reg + CNT_ONE;
          if (!seen_reg) begin
            seen_next  = 1'b1;
            first_next = idx_reg;
          end
        end
        // vec_addr is the index itself, so advancing idx also presents the next address.
        if ({1'b0, idx_reg} == num_reg - NUM_ONE) begin
          state_next = DONE;
        end else begin
          idx_next   = idx_reg + IDX_ONE;
          state_next = READ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.vec_addr       = idx_reg;
  assign bus.a              = a_reg;
  assign bus.b              = b_reg;
  assign bus.ALUControl     = ctrl_reg;
  assign bus.busy           = (state_reg == READ) || (state_reg == LOAD) || (state_reg == CHECK);
  assign bus.done           = (state_reg == DONE);
  assign bus.pass_count     = pass_reg;
  assign bus.fail_count     = fail_reg;
  assign bus.fail_seen      = seen_reg;
  assign bus.first_fail_idx = first_reg;
endmodule

// File: tb/tb_alu_vector_checker.sv
// Directed bench for alu_vector_checker: hosts a synchronous vector ROM and a reference ALU,
// predicts each run's statistics from the ROM contents, and checks timing and results.
module tb_alu_vector_checker;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 16;
  localparam int NROM   = 1 << ADDR_W;

  logic clk;
  logic reset;

  alu_vector_checker_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  alu_vector_checker #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [103:0] rom [NROM];

  int n_cmp  = 0;
  int n_fail = 0;

  int  exp_pass, exp_fail, exp_first;
  bit  exp_seen;
  bit  exp_valid = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.vec_data <= rom[bus.vec_addr];

  // Reference ALU: flags {N, Z, C, V}, subtraction carry is the no-borrow carry.
  function automatic logic [35:0] alu(input logic [1:0] ctrl, input logic [31:0] x, input logic [31:0] y);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (ctrl)
      2'b00: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[31:0]; c = s[32];
        v = (x[31] == y[31]) && (r[31] != x[31]);
      end
      2'b01: begin
        s = {1'b0, x} + {1'b0, ~y} + 33'd1;
        r = s[31:0]; c = s[32];
        v = (x[31] != y[31]) && (r[31] != x[31]);
      end
      2'b10:   r = x & y;
      default: r = x | y;
    endcase
    return {r, r[31], (r == 32'd0), c, v};
  endfunction

  always_comb {bus.Result, bus.ALUFlags} = alu(bus.ALUControl, bus.a, bus.b);

  function automatic logic [103:0] mkvec(input logic [1:0] ctrl, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] res,
                                          input logic [3:0] fl);
    return {2'b00, ctrl, x, y, res, fl};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int clampn(input int n);
    return (n > NROM) ? NROM : n;
  endfunction

  // Run-level prediction: which vectors of the ROM the ALU would reproduce exactly.
  task automatic predict(input int n);
    logic [103:0] v;
    exp_pass = 0; exp_fail = 0; exp_seen = 0; exp_first = 0;
    for (int i = 0; i < clampn(n); i++) begin
      v = rom[i];
      if (alu(v[101:100], v[99:68], v[67:36]) == v[35:0]) exp_pass++;
      else begin
        if (!exp_seen) exp_first = i;
        exp_seen = 1;
        exp_fail++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid && !reset && bus.done) begin
      check("pass_count", 64'(bus.pass_count), 64'(exp_pass));
      check("fail_count", 64'(bus.fail_count), 64'(exp_fail));
      check("fail_seen", 64'(bus.fail_seen), 64'(exp_seen));
      if (exp_seen) check("first_fail_idx", 64'(bus.first_fail_idx), 64'(exp_first));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_rom();
    for (int i = 0; i < NROM; i++)
      rom[i] = mkvec(2'(i % 4), 32'(i * 7), 32'(i), 32'd0, 4'd0);
    rom[0] = mkvec(2'b00, 32'h1, 32'h1, 32'h2, 4'b0000);
    rom[1] = mkvec(2'b01, 32'h5, 32'h5, 32'h0, 4'b0110);
    rom[2] = mkvec(2'b10, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 4'b0000);
    rom[3] = mkvec(2'b11, 32'h80000000, 32'h1, 32'h80000001, 4'b1000);
  endtask

  // One run: start edge, then 3 cycles per vector with address/operand checks, then DONE.
  task automatic run(input int n, input int glitch_k);
    int nv;
    logic [103:0] v;
    exp_valid = 0;
    predict(n);
    nv = clampn(n);
    bus.num_vectors = (ADDR_W + 1)'(n);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.num_vectors = '0;
    for (int k = 0; k < 3 * nv; k++) begin
      check("busy", 64'(bus.busy), 64'd1);
      check("done_early", 64'(bus.done), 64'd0);
      check("vec_addr", 64'(bus.vec_addr), 64'(k / 3));
      if (k % 3 == 2) begin
        v = rom[k / 3];
        check("drive", {bus.ALUControl, bus.a[29:0], bus.b}, {v[101:100], v[97:68], v[67:36]});
      end
      if (k == glitch_k) begin
        bus.start = 1'b1;
        bus.num_vectors = (ADDR_W + 1)'(5);
      end
      tick();
      bus.start = 1'b0;
      bus.num_vectors = '0;
    end
    check("done", 64'(bus.done), 64'd1);
    check("busy_done", 64'(bus.busy), 64'd0);
    exp_valid = 1;
    tick();
    tick();
    $display("run n=%0d: pass=%0d fail=%0d seen=%0d first=%0d", n, bus.pass_count,
             bus.fail_count, bus.fail_seen, bus.first_fail_idx);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vec_addr"}, 64'(bus.vec_addr), 64'd0);
    check({tag, "_operands"}, {bus.a, bus.b}, 64'd0);
    check({tag, "_ctrl"}, 64'(bus.ALUControl), 64'd0);
    check({tag, "_flags"}, {61'd0, bus.busy, bus.done, bus.fail_seen}, 64'd0);
    check({tag, "_counts"}, {bus.pass_count, bus.fail_count, 22'd0, bus.first_fail_idx}, 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.num_vectors = '0;
    init_rom();
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    run(4, -1);
    check("allpass_lit", {bus.pass_count, bus.fail_count, 31'd0, bus.fail_seen}, {16'd4, 16'd0, 32'd0});

    rom[1] = mkvec(2'b01, 32'h5, 32'h5, 32'h1, 4'b0110);
    rom[3] = mkvec(2'b11, 32'h80000000, 32'h1, 32'h80000001, 4'b0000);
    run(4, -1);
    check("inject_lit", {bus.pass_count, bus.fail_count, 15'd0, bus.fail_seen, 6'd0, bus.first_fail_idx},
          {16'd2, 16'd2, 16'd1, 16'd1});

    // Reset during CHECK of vector 2 while counters and operands are non-zero.
    exp_valid = 0;
    bus.num_vectors = (ADDR_W + 1)'(4);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (8) tick();
    check("premid_fail", 64'(bus.fail_count), 64'd1);
    reset = 1'b1;
    #1;
    check_all_zero("midrun");
    tick();
    reset = 1'b0;
    tick();
    check("idle_after_reset", {bus.busy, bus.done}, 64'd0);

    init_rom();
    run(4, -1);
    check("rerun_lit", 64'(bus.pass_count), 64'd4);

    rom[0] = mkvec(2'b00, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b1001);
    run(1, -1);
    check("ovf_pass_lit", {bus.pass_count, bus.fail_count}, {16'd1, 16'd0});
    rom[0] = mkvec(2'b00, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b1000);
    run(1, -1);
    check("ovf_fail_lit", {bus.pass_count, bus.fail_count, 15'd0, bus.fail_seen},
          {16'd0, 16'd1, 16'd1});

    run(0, -1);
    check("zero_lit", {bus.pass_count, bus.fail_count, 31'd0, bus.fail_seen}, 64'd0);

    init_rom();
    run(4, 4);
    check("glitch_lit", {bus.pass_count, bus.fail_count}, {16'd4, 16'd0});
    repeat (4) tick();
    check("done_hold", {bus.ALUControl, bus.a[29:0], bus.b}, {2'b11, 30'h0, 32'h1});

    run(2047, -1);
    check("clamp_lit", {bus.pass_count, bus.fail_count, 22'd0, bus.first_fail_idx},
          {16'd4, 16'd1020, 32'd4});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_vector_checker.md
Name: alu_vector_checker

Overview:
- Synthesizable on-chip self-test sequencer for the 32-bit ALU; the response-checking counterpart of the stimulus-only vector flow.
- Fetches 104-bit test vectors from a synchronous vector ROM, drives the ALU inputs, and captures Result/ALUFlags.
- Compares the captured outputs against the expected fields and reports pass/fail counts and the first failing vector index.
- Sits beside the ALU in the bring-up/BIST wrapper; the ALU is purely combinational between the registered drive outputs and the result inputs.

Parameters:
- ADDR_W, 10, vector ROM address width; max 2^ADDR_W vectors.
- CNT_W, 16, width of the pass/fail counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; starts a run from IDLE or DONE.
- num_vectors  input  ADDR_W+1  number of vectors to run; sampled on the accepted start.
- vec_addr  output  ADDR_W  ROM read address.
- vec_data  input  104  ROM read data; valid exactly 1 cycle after vec_addr.
- a  output  32  ALU operand A (registered).
- b  output  32  ALU operand B (registered).
- ALUControl  output  2  ALU mode (registered): 00 add, 01 sub, 10 and, 11 or.
- Result  input  32  ALU result.
- ALUFlags  input  4  ALU flags {N, Z, C, V}.
- busy  output  1  high in READ/LOAD/CHECK.
- done  output  1  high in DONE.
- pass_count  output  CNT_W  vectors matched.
- fail_count  output  CNT_W  vectors mismatched.
- fail_seen  output  1  at least one mismatch this run.
- first_fail_idx  output  ADDR_W  index of the first mismatching vector; valid when fail_seen=1.

Behaviour:
- Vector layout: vec_data[103:102] unused (ignored); [101:100] ALUControl; [99:68] a; [67:36] b; [35:4] expected Result; [3:0] expected ALUFlags.
- Reset (async, any state, mid-run included): state=IDLE; a, b, ALUControl, vec_addr, pass_count, fail_count, first_fail_idx = 0; busy, done, fail_seen = 0.
- FSM states: IDLE, READ, LOAD, CHECK, DONE.
- IDLE/DONE + start:
  - Clear the counters, fail_seen and first_fail_idx.
  - Latch num_vectors; set idx=0 and vec_addr=0.
  - If num_vectors=0, go to DONE; otherwise go to READ.
- Without start, DONE holds and all result outputs stay stable.
- READ (1 cycle): vec_addr=idx is presented; ROM data arrives on the next cycle.
- LOAD (1 cycle): register ALUControl, a and b from vec_data; register the expected Result/flags internally.
- CHECK (1 cycle): compare Result and ALUFlags with the expected values; a vector passes only if all 36 bits match.
  - Pass: pass_count++.
  - Fail: fail_count++; on the first failure only, set fail_seen=1 and first_fail_idx=idx.
  - If idx = latched num_vectors−1, go to DONE; otherwise idx++, vec_addr=idx+1, go to READ.
- Throughput: exactly 3 cycles per vector; a run of N vectors shows done high 3N+1 cycles after the start edge.
- start is ignored while busy.
- Counters saturate at 2^CNT_W−1; no wrap.
- num_vectors > 2^ADDR_W is clamped to 2^ADDR_W.
- a, b and ALUControl hold their last values in DONE/IDLE.

Test Plan:
- Reset mid-run: assert reset during CHECK of vector 2 → all outputs return to 0 asynchronously and state is IDLE; a subsequent start runs cleanly from vector 0.
- All-pass run: 4 vectors (add 1+1=2 flags 0; sub 5−5=0 flags 0110; and FFFF0000&0F0F0F0F=0F0F0000 flags 0; or 80000000|1=80000001 flags 1000) with a correct ALU → done at cycle 13; pass_count=4, fail_count=0, fail_seen=0.
- Injected errors: the same 4 vectors with the expected Result of vector 1 corrupted to 00000001 and the expected flags of vector 3 corrupted to 0000 → pass_count=2, fail_count=2, fail_seen=1, first_fail_idx=1.
- Overflow check: ALUControl=00, 7FFFFFFF+00000001, expected 80000000 flags 1001 → pass. The same vector with expected flags 1000 → fail (V bit only).
- Edge counts: num_vectors=0 → done 1 cycle after start, counts 0. num_vectors=1 → done at cycle 4.
- Start handling: start pulsed while busy → ignored, counts unaffected. start pulsed in DONE → counters clear and a new run begins; vec_addr sequence observed as 0,1,2,…
